// File: rtl/uart_tx_serializer_if.sv
// uart_tx_serializer_if: host-facing byte write port and serial line status of the 8N1 transmitter
interface uart_tx_serializer_if;
    logic [7:0] tx_data;
    logic       tx_write;
    logic       tx_out;
    logic       buffer_full;
    logic       tx_busy;
    logic       write_error;
    modport master (output tx_data, tx_write, input tx_out, buffer_full, tx_busy, write_error);
    modport slave (input tx_data, tx_write, output tx_out, buffer_full, tx_busy, write_error);
endinterface

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 8N1 transmitter with a one-entry holding buffer and a sticky dropped-write flag
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 10
) (
    input logic                  clk,
    input logic                  n_rst,
    uart_tx_serializer_if.slave  bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic [7:0]    r_buf;
    logic          r_full;
    logic          r_err;
    logic          r_tx;
    logic          r_busy;
    logic          w_last;
    logic          w_xfer;
    logic          w_accept;
    logic          w_drop;
    assign w_last   = r_cnt == LAST;
    // the buffer empties into the shifter when idle or exactly as a stop bit ends
    assign w_xfer   = r_full && (r_state == IDLE || (r_state == STOP && w_last));
    assign w_accept = bus.tx_write && (!r_full || w_xfer);
    assign w_drop   = bus.tx_write && r_full && !w_xfer;
    assign bus.tx_out      = r_tx;
    assign bus.buffer_full = r_full;
    assign bus.tx_busy     = r_busy;
    assign bus.write_error = r_err;
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_buf   <= '0;
            r_full  <= 1'b0;
            r_err   <= 1'b0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_buf <= bus.tx_data;
                r_err <= 1'b0;
            end else if (w_drop) begin
                r_err <= 1'b1;
            end
            r_full <= w_accept || (r_full && !w_xfer);
            if (w_xfer) begin
                r_shift <= r_buf;
                r_state <= START;
                r_cnt   <= '0;
                r_bit   <= '0;
                r_tx    <= 1'b0;
                r_busy  <= 1'b1;
            end else if (r_state != IDLE) begin
                r_cnt <= w_last ? '0 : r_cnt + CW'(1);
                if (w_last) begin
                    case (r_state)
                        START: begin
                            r_state <= DATA;
                            r_tx    <= r_shift[0];
                        end
                        DATA: begin
                            r_shift <= r_shift >> 1;
                            r_bit   <= r_bit + 3'd1;
                            r_state <= (r_bit == 3'd7) ? STOP : DATA;
                            r_tx    <= (r_bit == 3'd7) | r_shift[1];
                        end
                        default: begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end
    always @(clk) assert (!$isunknown(clk)) else $error("clk is X/Z");
    always @(posedge clk) begin
        assert (!$isunknown(n_rst)) else $error("n_rst is X/Z");
        assert (!$isunknown(bus.tx_write)) else $error("tx_write is X/Z");
        if (bus.tx_write === 1'b1) assert (!$isunknown(bus.tx_data)) else $error("tx_data is X/Z during write");
    end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: directed writes, expected bytes queued and checked by a serial-line monitor
module tb_uart_tx_serializer;
    localparam int CPB = 4;
    logic clk = 1'b0;
    logic n_rst = 1'b0;
    int total = 0;
    int passed = 0;
    logic [7:0] exp_q[$];
    uart_tx_serializer_if bus();
    uart_tx_serializer #(.CLKS_PER_BIT(CPB)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask
    function automatic logic [7:0] st();
        return {4'b0, bus.tx_out, bus.buffer_full, bus.tx_busy, bus.write_error};
    endfunction
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic wr(input logic [7:0] d, input bit accepted);
        bus.tx_write = 1'b1;
        bus.tx_data  = d;
        if (accepted) exp_q.push_back(d);
        @(negedge clk);
        bus.tx_write = 1'b0;
        bus.tx_data  = '0;
    endtask
    task automatic wait_idle(input int limit);
        for (int i = 0; i < limit && (bus.tx_busy || bus.buffer_full); i++) @(negedge clk);
        chk("drain", st(), 8'b1000);
    endtask
    // every cycle of a frame must match its bit; one comparison per bit period
    task automatic frame(output bit done);
        logic [7:0] d;
        logic [9:0] bits;
        bit ok;
        done = 1'b0;
        if (exp_q.size() == 0) begin
            total++;
            $display("FAIL unexpected_frame: got start bit, expected no frame");
            return;
        end
        d = exp_q.pop_front();
        bits = {1'b1, d, 1'b0};
        for (int b = 0; b < 10; b++) begin
            ok = 1'b1;
            for (int c = 0; c < CPB; c++) begin
                if (b != 0 || c != 0) @(negedge clk);
                if (!n_rst) return;
                if (bus.tx_out !== bits[b] || bus.tx_busy !== 1'b1) ok = 1'b0;
            end
            chk($sformatf("frame_%h_bit%0d", d, b), 8'(ok), 8'd1);
        end
        done = 1'b1;
    endtask
    initial begin
        bit post;
        post = 1'b0;
        forever begin
            @(negedge clk);
            if (!n_rst) post = 1'b0;
            else if (!bus.tx_out) frame(post);
            else if (post) begin
                chk("busy_end", 8'(bus.tx_busy), 8'd0);
                post = 1'b0;
            end
        end
    end
    initial begin
        bus.tx_write = 1'b0;
        bus.tx_data  = '0;
        idle(2);
        n_rst = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("idle", st(), 8'b1000);
        end
        wr(8'hA5, 1);
        chk("a5_buffered", st(), 8'b1100);
        idle(1);
        chk("a5_start", st(), 8'b0010);
        wait_idle(60);
        idle(3);
        wr(8'h3C, 1);
        chk("3c_buffered", st(), 8'b1100);
        idle(1);
        chk("3c_start", st(), 8'b0010);
        idle(5);
        wr(8'hF0, 1);
        chk("f0_buffered", 8'({bus.buffer_full, bus.write_error}), 8'b10);
        idle(4);
        wr(8'h11, 0);
        chk("11_dropped", 8'({bus.buffer_full, bus.write_error}), 8'b11);
        idle(28);
        chk("3c_last_stop", st(), 8'b1111);
        wr(8'h22, 1);
        chk("22_on_last_stop", st(), 8'b0110);
        wait_idle(150);
        idle(2);
        wr(8'h55, 1);
        idle(3);
        wr(8'h66, 1);
        chk("66_buffered", 8'({bus.buffer_full, bus.write_error}), 8'b10);
        idle(36);
        wr(8'h77, 1);
        chk("77_on_last_stop", st(), 8'b0110);
        wait_idle(150);
        idle(2);
        wr(8'h5A, 1);
        idle(1);
        chk("5a_start", st(), 8'b0010);
        idle(2);
        wr(8'h99, 0);
        chk("99_buffered", 8'(bus.buffer_full), 8'd1);
        idle(17);
        #2 n_rst = 1'b0;
        #1 chk("reset_async", st(), 8'b1000);
        idle(2);
        n_rst = 1'b1;
        chk("reset_hold", st(), 8'b1000);
        idle(1);
        wr(8'h81, 1);
        chk("81_buffered", st(), 8'b1100);
        idle(1);
        chk("81_start", st(), 8'b0010);
        wait_idle(60);
        idle(2);
        chk("queue_empty", 8'(exp_q.size()), 8'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
